// File: rtl/up_pkg.sv
// Shared definitions for the register-bus master: FSM state encoding and
// default address/data widths and ACCESS timeout length.
// Latency: n/a. Backpressure: n/a.
package up_pkg;

    localparam int AW_DEF   = 8;
    localparam int DW_DEF   = 8;
    localparam int TOUT_DEF = 255;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        TURN   = 2'd2
    } state_t;

endpackage

// File: rtl/up_tocnt.sv
// ACCESS timeout counter: clears on clr, counts enabled cycles, flags the last allowed one.
// Latency: expire is combinational from the count; count advances one per en cycle.
// Backpressure: none; saturates at TOUT-1 until cleared.
// Ports: clk, rst (sync, active-high), clr (restart at 0), en (count this cycle),
//        expire (count has reached TOUT-1).
module up_tocnt
    import up_pkg::*;
#(
    parameter int TOUT = TOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(TOUT);

    logic [CW-1:0] cnt;

    assign expire = (cnt == CW'(TOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && !expire) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/up_master.sv
// Register-bus master: takes one valid/ready request, runs one upen/strobe access, returns a one-cycle response.
// Latency: 3 cycles acceptance-to-rsp_vld with a 1-cycle slave ack; TURN then waits for upack to drop.
// Backpressure: req_rdy only in IDLE (no queueing); responses have no backpressure.
// Ports: clk, rst (sync, active-high); req_vld/req_rdy/req_wr/req_addr/req_wdata request side;
//        rsp_vld/rsp_rdata/rsp_err response pulse; upen/uprs/upws/upa/updi/updo/upack register bus.
// Build option: define UP_MASTER_TIMEOUT_EN to abort ACCESS after TOUT cycles without upack
// (rsp_err=1, rsp_rdata=0); otherwise ACCESS waits forever and rsp_err is tied low.
module up_master
    import up_pkg::*;
#(
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF,
    parameter int TOUT = TOUT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_vld,
    output logic          req_rdy,
    input  logic          req_wr,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_vld,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          upen,
    output logic          uprs,
    output logic          upws,
    output logic [AW-1:0] upa,
    output logic [DW-1:0] updi,
    input  logic [DW-1:0] updo,
    input  logic          upack
);

    // TOUT outside 2..65535 is a configuration error caught at elaboration.
    if (TOUT < 2 || TOUT > 65535) begin : g_bad_tout
        $error("up_master: TOUT out of range");
    end

    state_t state;
    state_t state_nxt;
    logic   accept;
    logic   wr_q;
    logic   expire;

    assign accept = req_vld && req_rdy;

`ifdef UP_MASTER_TIMEOUT_EN
    up_tocnt #(
        .TOUT(TOUT)
    ) u_tocnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (accept),
        .en     (state == ACCESS),
        .expire (expire)
    );

    // Error flag is refreshed at every ACCESS edge; upack beats a coincident timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_err <= 1'b0;
        end else if (state == ACCESS) begin
            rsp_err <= !upack && expire;
        end
    end
`else
    assign expire  = 1'b0;
    assign rsp_err = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state. TURN holds until upack is seen low so a lingering ack
    // from this access cannot complete the next one.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)          state_nxt = ACCESS;
            ACCESS:  if (upack || expire) state_nxt = TURN;
            TURN:    if (!upack)          state_nxt = IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state; req_rdy is also masked by rst in its own cycle.
    always_comb begin
        req_rdy = (state == IDLE) && !rst;
        upen    = (state == ACCESS);
        uprs    = (state == ACCESS) && !wr_q;
        upws    = (state == ACCESS) && wr_q;
    end

    // Request capture and response generation
    always_ff @(posedge clk) begin
        if (rst) begin
            upa       <= '0;
            updi      <= '0;
            wr_q      <= 1'b0;
            rsp_vld   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_vld <= 1'b0;
            if (accept) begin
                upa  <= req_addr;
                updi <= req_wdata;
                wr_q <= req_wr;
            end
            if (state == ACCESS) begin
                if (upack) begin
                    rsp_vld <= 1'b1;
                    if (!wr_q) begin
                        rsp_rdata <= updo;
                    end
                end else if (expire) begin
                    rsp_vld   <= 1'b1;
                    rsp_rdata <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_up_master.sv
// Self-checking bench for up_master: directed scenarios plus randomized
// transactions against a cycle-indexed transaction model; the bench acts as the slave.
// Build option UP_MASTER_TIMEOUT_EN selects the timeout scenario (TOUT=4).
module tb_up_master;

    localparam int TOUT_TB = 4;
`ifdef UP_MASTER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       req_vld;
    logic       req_rdy;
    logic       req_wr;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_vld;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       upen;
    logic       uprs;
    logic       upws;
    logic [7:0] upa;
    logic [7:0] updi;
    logic [7:0] updo;
    logic       upack;

    int         checks;
    int         failures;
    logic [7:0] model_rdata;

    up_master #(
        .AW   (8),
        .DW   (8),
        .TOUT (TOUT_TB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_vld   (req_vld),
        .req_rdy   (req_rdy),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_vld   (rsp_vld),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .upen      (upen),
        .uprs      (uprs),
        .upws      (upws),
        .upa       (upa),
        .updi      (updi),
        .updo      (updo),
        .upack     (upack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One transaction, cycle 0 = the cycle the request is offered in IDLE.
    // Slave acks at cycle ack_dly+1 and keeps upack for 'hold' cycles after the
    // last strobe cycle. Expected timing is derived from the protocol rules:
    // strobes in cycles 1..s, response in cycle s+1, IDLE once upack is low in TURN.
    task automatic do_txn(input string nm, input bit wr, input logic [7:0] addr,
                          input logic [7:0] wdata, input logic [7:0] rdv,
                          input int ack_dly, input int hold, input bit never_ack,
                          input bit keep_vld);
        int         ack_cycle;
        int         ack_end;
        int         s;
        int         idle_c;
        bit         timed_out;
        bit         ack_c;
        bit         exp_en;
        logic [7:0] exp_rd;

        ack_cycle = never_ack ? (1 << 30) : ack_dly + 1;
        s         = ack_cycle;
        timed_out = 1'b0;
        if (TO_EN && ack_cycle > TOUT_TB) begin
            timed_out = 1'b1;
            s         = TOUT_TB;
        end
        ack_end = (s >= ack_cycle) ? s + hold : ack_cycle;
        idle_c  = s + 1;
        while (!never_ack && idle_c >= ack_cycle && idle_c <= ack_end) idle_c++;
        idle_c = idle_c + 1;

        if (timed_out)  exp_rd = 8'h00;
        else if (wr)    exp_rd = model_rdata;
        else            exp_rd = rdv;

        for (int c = 0; c < idle_c; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) begin
                req_vld   = 1'b1;
                req_wr    = wr;
                req_addr  = addr;
                req_wdata = wdata;
            end else begin
                req_vld   = keep_vld;
                req_wr    = 1'($urandom);
                req_addr  = 8'($urandom);
                req_wdata = 8'($urandom);
            end
            ack_c = !never_ack && c >= ack_cycle && c <= ack_end;
            upack = ack_c;
            updo  = ack_c ? rdv : 8'($urandom);

            @(negedge clk);
            exp_en = (c >= 1) && (c <= s);
            checks++;
            if (req_rdy !== (c == 0))
                $display("FAIL %s req_rdy c=%0d got=%b exp=%b", nm, c, req_rdy, (c == 0));
            checks++;
            if ({upen, uprs, upws} !== {exp_en, exp_en && !wr, exp_en && wr}) begin
                failures++;
                $display("FAIL %s strobes c=%0d got=%b%b%b exp=%b%b%b", nm, c,
                         upen, uprs, upws, exp_en, exp_en && !wr, exp_en && wr);
            end
            if (exp_en) begin
                checks++;
                if (upa !== addr || updi !== wdata) begin
                    failures++;
                    $display("FAIL %s bus_hold c=%0d upa=%h/%h updi=%h/%h", nm, c,
                             upa, addr, updi, wdata);
                end
            end
            checks++;
            if (rsp_vld !== (c == s + 1)) begin
                failures++;
                $display("FAIL %s rsp_vld c=%0d got=%b exp=%b", nm, c, rsp_vld, (c == s + 1));
            end
            if (c == s + 1) begin
                checks++;
                if (rsp_rdata !== exp_rd || rsp_err !== timed_out) begin
                    failures++;
                    $display("FAIL %s rsp c=%0d rdata=%h exp=%h err=%b exp=%b", nm, c,
                             rsp_rdata, exp_rd, rsp_err, timed_out);
                end
            end
            if (req_rdy !== (c == 0)) failures++;
        end
        model_rdata = exp_rd;
    endtask

    task automatic check_all_zero(input string nm);
        logic [28:0] outs;
        outs = {upen, uprs, upws, upa, updi, rsp_vld, rsp_rdata, rsp_err};
        checks++;
        if (outs !== '0) begin
            failures++;
            $display("FAIL %s outputs got=%h exp=0", nm, outs);
        end
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        req_vld = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (req_rdy !== 1'b0) begin
            failures++;
            $display("FAIL reset req_rdy_in_rst got=%b exp=0", req_rdy);
        end
        check_all_zero("reset_in_rst");
        @(posedge clk);
        #1;
        rst     = 1'b0;
        req_vld = 1'b0;
        @(negedge clk);
        checks++;
        if (req_rdy !== 1'b1) begin
            failures++;
            $display("FAIL reset req_rdy_after got=%b exp=1", req_rdy);
        end
        check_all_zero("reset_after");
        model_rdata = 8'h00;
    endtask

    task automatic test_read();
        do_txn("read", 1'b0, 8'h12, 8'h00, 8'hA5, 1, 1, 1'b0, 1'b0);
    endtask

    task automatic test_write();
        do_txn("write", 1'b1, 8'h34, 8'h5A, 8'hEE, 4, 1, 1'b0, 1'b0);
    endtask

    task automatic test_linger();
        do_txn("linger", 1'b0, 8'h21, 8'h00, 8'h3C, 1, 3, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_txn("b2b_1", 1'b0, 8'h40, 8'h00, 8'h6B, 1, 1, 1'b0, 1'b1);
        do_txn("b2b_2", 1'b1, 8'h41, 8'h99, 8'h00, 2, 1, 1'b0, 1'b0);
    endtask

    // Reset on the second ACCESS cycle, then a stale ack arrives while IDLE.
    task automatic test_reset_mid();
        @(posedge clk);
        #1;
        req_vld = 1'b1; req_wr = 1'b0; req_addr = 8'h66; req_wdata = 8'h00;
        upack = 1'b0;
        @(posedge clk);
        #1;
        req_vld = 1'b0;
        @(negedge clk);
        checks++;
        if (upen !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid access1 upen got=%b exp=1", upen);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        upack = 1'b1;
        updo  = 8'hFF;
        @(negedge clk);
        check_all_zero("rst_mid_after");
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            checks++;
            if (rsp_vld !== 1'b0 || upen !== 1'b0 || req_rdy !== 1'b1) begin
                failures++;
                $display("FAIL rst_mid stale_ack k=%0d rsp_vld=%b upen=%b req_rdy=%b exp=0/0/1",
                         k, rsp_vld, upen, req_rdy);
            end
        end
        @(posedge clk);
        #1;
        upack = 1'b0;
        model_rdata = 8'h00;
        do_txn("rst_mid_next", 1'b0, 8'h67, 8'h00, 8'hC3, 1, 1, 1'b0, 1'b0);
    endtask

`ifdef UP_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        do_txn("timeout", 1'b0, 8'h55, 8'h00, 8'h11, 1, 0, 1'b1, 1'b0);
        do_txn("ack_at_tout", 1'b0, 8'h56, 8'h00, 8'h22, TOUT_TB - 1, 1, 1'b0, 1'b0);
    endtask
`else
    task automatic test_timeout();
        @(posedge clk);
        #1;
        req_vld = 1'b1; req_wr = 1'b0; req_addr = 8'h77; upack = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk);
            #1;
            req_vld = 1'b0;
            @(negedge clk);
            checks++;
            if (upen !== 1'b1 || uprs !== 1'b1 || rsp_vld !== 1'b0 || rsp_err !== 1'b0) begin
                failures++;
                $display("FAIL no_timeout c=%0d upen=%b uprs=%b rsp_vld=%b rsp_err=%b exp=1/1/0/0",
                         c, upen, uprs, rsp_vld, rsp_err);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_rdata = 8'h00;
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 10; i++) begin
            do_txn("random", 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                   int'($urandom_range(1, 6)), int'($urandom_range(0, 3)), 1'b0,
                   (i < 9) ? 1'($urandom) : 1'b0);
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        model_rdata = 8'h00;
        rst         = 1'b1;
        req_vld     = 1'b0;
        req_wr      = 1'b0;
        req_addr    = 8'h00;
        req_wdata   = 8'h00;
        updo        = 8'h00;
        upack       = 1'b0;

        test_reset();
        test_read();
        test_write();
        test_linger();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        test_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
